sd_wrrmux: RTL

//  Weighted, packet-aware round-robin mux on srdy/drdy handshakes. Merges N

---
 rtl/sd_wrrmux_if.sv | 33 +++
 rtl/sd_wrrmux.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sd_wrrmux_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_wrrmux_if : channel-side and packet-side srdy/drdy bundle          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sd_wrrmux_if #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int WT_SZ  = 4
);
  logic [INPUTS-1:0]       c_srdy;
  logic [INPUTS-1:0]       c_drdy;
  logic [WIDTH*INPUTS-1:0] c_data;
  logic [INPUTS-1:0]       c_eop;
  logic [WT_SZ*INPUTS-1:0] c_weight;
  logic                    p_srdy;
  logic                    p_drdy;
  logic [WIDTH-1:0]        p_data;
  logic                    p_eop;
  logic [INPUTS-1:0]       p_grant;

  // The mux itself: consumes channels, produces the merged stream.
  modport slave (
    input  c_srdy, c_data, c_eop, c_weight, p_drdy,
    output c_drdy, p_srdy, p_data, p_eop, p_grant
  );

  modport master (
    output c_srdy, c_data, c_eop, c_weight, p_drdy,
    input  c_drdy, p_srdy, p_data, p_eop, p_grant
  );
endinterface
`default_nettype wire

// File: rtl/sd_wrrmux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sd_wrrmux : weighted packet-aware round-robin srdy/drdy mux           |
// | Optional per-channel packet counters: SD_WRRMUX_PERF_EN   Rev 1.0     |
// +-----------------------------------------------------------------------+
module sd_wrrmux #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int WT_SZ  = 4
) (
  input  wire logic   clk,
  input  wire logic   reset,
  sd_wrrmux_if.slave  bus
`ifdef SD_WRRMUX_PERF_EN
  ,
  output logic [32*INPUTS-1:0] p_pkt_cnt
`endif
);
  localparam int ISZ = $clog2(INPUTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PKT   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t           st_q, st_d;
  logic [ISZ-1:0]   g_q, g_d, last_q, last_d;
  logic [WT_SZ-1:0] cred_q, cred_d, cred_base, wt_g;
  logic [ISZ-1:0]   arb_start, arb_idx, gnt;
  logic             arb_hit, gnt_vld, forfeit, xfer;
  logic [WT_SZ:0]   cred_inc, wt_eff;

  // First requester strictly after 'start', wrapping; MSB flags a hit.
  function automatic logic [ISZ:0] rr_pick(input logic [INPUTS-1:0] req,
                                           input logic [ISZ-1:0]    start);
    logic [ISZ:0] res;
    int           j;
    res = '0;
    for (int i = INPUTS; i >= 1; i--) begin
      j = (int'(start) + i) % INPUTS;
      if (req[ISZ'(j)]) res = {1'b1, ISZ'(j)};
    end
    return res;
  endfunction

  always_comb begin
    forfeit   = (st_q == ST_BURST) && !bus.c_srdy[g_q];
    arb_start = (st_q == ST_BURST) ? g_q : last_q;
    {arb_hit, arb_idx} = rr_pick(bus.c_srdy, arb_start);
    gnt     = arb_idx;
    gnt_vld = arb_hit;
    if (st_q == ST_PKT || (st_q == ST_BURST && !forfeit)) begin
      gnt     = g_q;
      gnt_vld = 1'b1;
    end
  end

  always_comb begin
    bus.c_drdy  = '0;
    bus.p_grant = '0;
    bus.p_srdy  = 1'b0;
    bus.p_data  = bus.c_data[gnt*WIDTH +: WIDTH];
    bus.p_eop   = bus.c_eop[gnt];
    if (gnt_vld) begin
      bus.p_grant[gnt] = 1'b1;
      bus.c_drdy[gnt]  = bus.p_drdy;
      bus.p_srdy       = bus.c_srdy[gnt];
    end
  end

  assign xfer = bus.p_srdy & bus.p_drdy;

  always_comb begin
    st_d      = st_q;
    g_d       = g_q;
    last_d    = last_q;
    cred_d    = cred_q;
    wt_g      = bus.c_weight[gnt*WT_SZ +: WT_SZ];
    wt_eff    = (wt_g == '0) ? (WT_SZ+1)'(1) : {1'b0, wt_g};
    cred_base = forfeit ? '0 : cred_q;
    cred_inc  = {1'b0, cred_base} + (WT_SZ+1)'(1);
    // An idle burst holder gives up its turn before this cycle's arbitration.
    if (forfeit) begin
      st_d   = ST_IDLE;
      last_d = g_q;
      cred_d = '0;
    end
    if (xfer) begin
      g_d = gnt;
      if (!bus.p_eop) begin
        st_d   = ST_PKT;
        cred_d = cred_base;
      end else if (cred_inc >= wt_eff) begin
        st_d   = ST_IDLE;
        last_d = gnt;
        cred_d = '0;
      end else begin
        st_d   = ST_BURST;
        cred_d = cred_inc[WT_SZ-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q   <= ST_IDLE;
      g_q    <= '0;
      last_q <= ISZ'(INPUTS-1);
      cred_q <= '0;
    end else begin
      st_q   <= st_d;
      g_q    <= g_d;
      last_q <= last_d;
      cred_q <= cred_d;
    end
  end

`ifdef SD_WRRMUX_PERF_EN
  generate
    for (genvar i = 0; i < INPUTS; i++) begin : g_perf
      logic [31:0] cnt_q;
      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_q <= '0;
        end else if (xfer && bus.p_eop && gnt == ISZ'(i)) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
      assign p_pkt_cnt[i*32 +: 32] = cnt_q;
    end
  endgenerate
`endif
endmodule
`default_nettype wire
